// File: rtl/card_map_ctrl.sv
// Board state owner for the card table: per-cell card types, selection flags, cursor and a one-card hand.
// Executes decoded single-step commands (two-cycle IDLE/EXEC handshake) and dealer direct cell writes.
module card_map_ctrl #(
    parameter int ROWS   = 8,
    parameter int COLS   = 18,
    parameter int TYPE_W = 6,
    parameter int EMPTY  = 54
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    input  logic [2:0]                    cmd,
    output logic                          cmd_ready,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_pos,
    input  logic [TYPE_W-1:0]             wr_type,
    output logic [ROWS*COLS*TYPE_W-1:0]   map,
    output logic [ROWS*COLS-1:0]          sel_card,
    output logic [7:0]                    cursor_pos,
    output logic                          held,
    output logic [TYPE_W-1:0]             held_type,
    output logic                          done,
    output logic                          err
);
    localparam int CELLS = ROWS * COLS;
    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);
    localparam logic [7:0]        CELLS_P = 8'(CELLS);
    localparam logic [TYPE_W-1:0] EMPTY_T = TYPE_W'(EMPTY);
    localparam logic [XW-1:0]     X_MAX   = XW'(COLS - 1);
    localparam logic [YW-1:0]     Y_MAX   = YW'(ROWS - 1);

    localparam logic [2:0] OP_UP = 3'd1, OP_DOWN = 3'd2, OP_LEFT = 3'd3, OP_RIGHT = 3'd4;
    localparam logic [2:0] OP_TOGGLE = 3'd5, OP_PICK = 3'd6, OP_CLEAR = 3'd7;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [TYPE_W-1:0]  cell_q [CELLS];
    logic [TYPE_W-1:0]  cell_d [CELLS];
    logic [CELLS-1:0]   sel_q, sel_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [7:0]         pos_q, pos_d;
    logic               held_q, held_d;
    logic [TYPE_W-1:0]  held_type_q, held_type_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [TYPE_W-1:0]  cur_cell;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cell_d      = cell_q;
        sel_d       = sel_q;
        x_d         = x_q;
        y_d         = y_q;
        held_d      = held_q;
        held_type_d = held_type_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cur_cell    = cell_q[pos_q];

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && cmd_valid) begin
                    cmd_d   = cmd;
                    state_d = EXEC;
                end
                // The write lands before the accepted command executes, so it sees the new cell.
                if (wr_en) begin
                    if (wr_pos < CELLS_P) begin
                        cell_d[wr_pos] = wr_type;
                        sel_d[wr_pos]  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (wr_en) begin
                    err_d = 1'b1;
                end
                case (cmd_q)
                    OP_UP:    y_d = (y_q == '0)    ? Y_MAX : y_q - YW'(1);
                    OP_DOWN:  y_d = (y_q == Y_MAX) ? '0    : y_q + YW'(1);
                    OP_LEFT:  x_d = (x_q == '0)    ? X_MAX : x_q - XW'(1);
                    OP_RIGHT: x_d = (x_q == X_MAX) ? '0    : x_q + XW'(1);
                    OP_TOGGLE: begin
                        if (cur_cell == EMPTY_T) begin
                            err_d = 1'b1;
                        end else begin
                            sel_d[pos_q] = ~sel_q[pos_q];
                        end
                    end
                    OP_PICK: begin
                        if (!held_q) begin
                            if (cur_cell == EMPTY_T) begin
                                err_d = 1'b1;
                            end else begin
                                held_d        = 1'b1;
                                held_type_d   = cur_cell;
                                cell_d[pos_q] = EMPTY_T;
                                sel_d[pos_q]  = 1'b0;
                            end
                        end else if (cur_cell == EMPTY_T) begin
                            cell_d[pos_q] = held_type_q;
                            held_d        = 1'b0;
                            held_type_d   = EMPTY_T;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_CLEAR: sel_d = '0;
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        pos_d       = 8'(x_d) + 8'(y_d) * 8'(COLS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            cmd_q       <= '0;
            sel_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pos_q       <= '0;
            held_q      <= 1'b0;
            held_type_q <= EMPTY_T;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_q       <= cmd_d;
            sel_q       <= sel_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pos_q       <= pos_d;
            held_q      <= held_d;
            held_type_q <= held_type_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Cells stay in flops: the renderer needs every cell in parallel every cycle.
    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
            always_ff @(posedge clk) begin
                if (rst) begin
                    cell_q[gi] <= EMPTY_T;
                end else begin
                    cell_q[gi] <= cell_d[gi];
                end
            end
            assign map[gi*TYPE_W +: TYPE_W] = cell_q[gi];
        end
    endgenerate

    assign cmd_ready  = cmd_ready_q;
    assign sel_card   = sel_q;
    assign cursor_pos = pos_q;
    assign held       = held_q;
    assign held_type  = held_type_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_card_map_ctrl.sv
// Randomized self-checking bench for card_map_ctrl against a board-level reference model.
module tb_card_map_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd = '0;
    logic         cmd_ready;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_pos = '0;
    logic [5:0]   wr_type = '0;
    logic [863:0] map;
    logic [143:0] sel_card;
    logic [7:0]   cursor_pos;
    logic         held;
    logic [5:0]   held_type;
    logic         done;
    logic         err;

    card_map_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .wr_en(wr_en), .wr_pos(wr_pos), .wr_type(wr_type), .map(map), .sel_card(sel_card),
        .cursor_pos(cursor_pos), .held(held), .held_type(held_type), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: board as plain arrays, cursor as (column,row)
    int m_map [144];
    bit m_sel [144];
    int mx, my;
    bit m_held;
    int m_type;

    task automatic model_reset();
        for (int i = 0; i < 144; i++) begin
            m_map[i] = 54;
            m_sel[i] = 1'b0;
        end
        mx = 0; my = 0; m_held = 1'b0; m_type = 54;
    endtask

    task automatic model_write(input int pos, input int typ, output bit e);
        e = (pos >= 144);
        if (!e) begin
            m_map[pos] = typ;
            m_sel[pos] = 1'b0;
        end
    endtask

    task automatic model_cmd(input int c, output bit e);
        int idx;
        idx = mx + my * 18;
        e = 1'b0;
        case (c)
            1: my = (my + 7) % 8;
            2: my = (my + 1) % 8;
            3: mx = (mx + 17) % 18;
            4: mx = (mx + 1) % 18;
            5: if (m_map[idx] == 54) e = 1'b1; else m_sel[idx] = !m_sel[idx];
            6: begin
                if (!m_held) begin
                    if (m_map[idx] == 54) e = 1'b1;
                    else begin
                        m_type = m_map[idx]; m_held = 1'b1; m_map[idx] = 54; m_sel[idx] = 1'b0;
                    end
                end else if (m_map[idx] == 54) begin
                    m_map[idx] = m_type; m_held = 1'b0; m_type = 54;
                end else e = 1'b1;
            end
            7: for (int i = 0; i < 144; i++) m_sel[i] = 1'b0;
            default: ;
        endcase
    endtask

    function automatic logic [863:0] exp_map();
        logic [863:0] r;
        for (int i = 0; i < 144; i++) r[i*6 +: 6] = 6'(m_map[i]);
        return r;
    endfunction

    function automatic logic [143:0] exp_sel();
        logic [143:0] r;
        for (int i = 0; i < 144; i++) r[i] = m_sel[i];
        return r;
    endfunction

    function automatic logic [7:0] exp_pos();
        return 8'(mx + my * 18);
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL ready_timeout: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
        end
    endtask

    // Issues one command; returns done/err sampled two cycles after acceptance.
    task automatic run_cmd(input int c, output logic o_done, output logic o_err, output bit e_exp);
        bit ok;
        wait_ready(ok);
        e_exp = 1'b0; o_done = 1'bx; o_err = 1'bx;
        if (!ok) return;
        cmd_valid = 1'b1; cmd = 3'(c);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_cmd(c, e_exp);
        @(negedge clk);
        @(negedge clk);
        o_done = done; o_err = err;
        $display("cmd op=%0d cursor=%0d held=%b done=%b err=%b", c, cursor_pos, held, done, err);
    endtask

    task automatic do_write(input int pos, input int typ, output logic o_err, output bit e_exp);
        bit ok;
        wait_ready(ok);
        e_exp = 1'b0; o_err = 1'bx;
        if (!ok) return;
        wr_en = 1'b1; wr_pos = 8'(pos); wr_type = 6'(typ);
        @(posedge clk); #1;
        wr_en = 1'b0;
        model_write(pos, typ, e_exp);
        @(negedge clk);
        o_err = err;
        $display("write pos=%0d type=%0d err=%b", pos, typ, err);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_low: cmd_ready=%b required 0", cmd_ready);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (map !== exp_map() || sel_card !== '0 || cursor_pos !== 8'd0 || held !== 1'b0 ||
            held_type !== 6'd54 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cursor=%0d held=%b held_type=%0d done=%b err=%b sel_zero=%b map_ok=%b required 0/0/54/0/0/1/1",
                     cursor_pos, held, held_type, done, err, sel_card == '0, map === exp_map());
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_high: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_cursor();
        int ops [4] = '{3, 1, 2, 4};
        int exps [4] = '{17, 143, 17, 0};
        logic d, e; bit ee;
        for (int k = 0; k < 4; k++) begin
            run_cmd(ops[k], d, e, ee);
            total++;
            if (cursor_pos !== 8'(exps[k]) || d !== 1'b1 || e !== 1'b0) begin
                bad++;
                $display("FAIL cursor_wrap op=%0d: cursor=%0d done=%b err=%b required %0d/1/0",
                         ops[k], cursor_pos, d, e, exps[k]);
            end
        end
        for (int k = 0; k < 30; k++) begin
            run_cmd(int'($urandom_range(1, 4)), d, e, ee);
            total++;
            if (cursor_pos !== exp_pos() || d !== 1'b1 || e !== ee) begin
                bad++;
                $display("FAIL cursor_random: cursor=%0d done=%b err=%b required %0d/1/%b",
                         cursor_pos, d, e, exp_pos(), ee);
            end
        end
        while (mx != 0) run_cmd(3, d, e, ee);
        while (my != 0) run_cmd(1, d, e, ee);
    endtask

    task automatic test_select();
        logic d, e; bit ee;
        do_write(20, 5, e, ee);
        total++;
        if (e !== 1'b0 || map[125:120] !== 6'd5 || sel_card[20] !== 1'b0) begin
            bad++; $display("FAIL write_cell20: err=%b cell=%0d sel=%b required 0/5/0", e, map[125:120], sel_card[20]);
        end
        run_cmd(4, d, e, ee); run_cmd(4, d, e, ee); run_cmd(2, d, e, ee);
        total++;
        if (cursor_pos !== 8'd20) begin
            bad++; $display("FAIL cursor_to_20: cursor=%0d required 20", cursor_pos);
        end
        run_cmd(5, d, e, ee);
        total++;
        if (sel_card[20] !== 1'b1 || e !== 1'b0 || d !== 1'b1 || sel_card !== exp_sel()) begin
            bad++; $display("FAIL toggle_sel: sel20=%b err=%b done=%b required 1/0/1", sel_card[20], e, d);
        end
        run_cmd(4, d, e, ee);
        run_cmd(5, d, e, ee);
        total++;
        if (e !== 1'b1 || d !== 1'b1 || sel_card !== exp_sel() || sel_card[21] !== 1'b0) begin
            bad++; $display("FAIL toggle_empty: err=%b done=%b sel21=%b required 1/1/0", e, d, sel_card[21]);
        end
    endtask

    task automatic test_pick_place();
        logic d, e; bit ee;
        run_cmd(3, d, e, ee);
        run_cmd(6, d, e, ee);
        total++;
        if (held !== 1'b1 || held_type !== 6'd5 || map[125:120] !== 6'd54 || sel_card[20] !== 1'b0 || e !== 1'b0) begin
            bad++;
            $display("FAIL pick: held=%b type=%0d cell20=%0d sel20=%b err=%b required 1/5/54/0/0",
                     held, held_type, map[125:120], sel_card[20], e);
        end
        do_write(3, 9, e, ee);
        run_cmd(1, d, e, ee); run_cmd(4, d, e, ee);
        run_cmd(6, d, e, ee);
        total++;
        if (cursor_pos !== 8'd3 || e !== 1'b1 || held !== 1'b1 || map !== exp_map() || map[23:18] !== 6'd9) begin
            bad++; $display("FAIL place_occupied: cursor=%0d err=%b held=%b cell3=%0d required 3/1/1/9",
                            cursor_pos, e, held, map[23:18]);
        end
        run_cmd(4, d, e, ee);
        run_cmd(6, d, e, ee);
        total++;
        if (map[29:24] !== 6'd5 || held !== 1'b0 || held_type !== 6'd54 || e !== 1'b0 || d !== 1'b1) begin
            bad++; $display("FAIL place_empty: cell4=%0d held=%b type=%0d err=%b required 5/0/54/0",
                            map[29:24], held, held_type, e);
        end
    endtask

    task automatic test_write_drop();
        bit ok, ee;
        logic e;
        wait_ready(ok);
        if (ok) begin
            cmd_valid = 1'b1; cmd = 3'd0;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            wr_en = 1'b1; wr_pos = 8'd10; wr_type = 6'd7;
            @(posedge clk); #1;
            wr_en = 1'b0;
            @(negedge clk);
            $display("nop with write in exec done=%b err=%b", done, err);
            total++;
            if (done !== 1'b1 || err !== 1'b1 || map !== exp_map()) begin
                bad++; $display("FAIL write_in_exec: done=%b err=%b cell10=%0d required 1/1/%0d",
                                done, err, map[65:60], m_map[10]);
            end
        end
        do_write(200, 3, e, ee);
        total++;
        if (e !== 1'b1 || ee !== 1'b1 || done !== 1'b0 || map !== exp_map()) begin
            bad++; $display("FAIL write_out_of_range: err=%b done=%b map_ok=%b required 1/0/1",
                            e, done, map === exp_map());
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_pulse_width: err=%b required 0", err);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, ee;
        int acc;
        acc = 0;
        wait_ready(ok);
        if (!ok) return;
        cmd_valid = 1'b1; cmd = 3'd4;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready === 1'b1) begin
                acc++;
                model_cmd(4, ee);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        $display("back_to_back accepted=%0d cursor=%0d", acc, cursor_pos);
        total++;
        if (acc != 6 || cursor_pos !== exp_pos()) begin
            bad++; $display("FAIL back_to_back: accepted=%0d cursor=%0d required 6/%0d", acc, cursor_pos, exp_pos());
        end
    endtask

    task automatic test_random();
        logic d, e; bit ee, we, ok;
        int r, c, p, t;
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            p = int'($urandom_range(0, 159));
            t = int'($urandom_range(0, 63));
            c = int'($urandom_range(0, 7));
            if (r < 3) begin
                do_write(p, t, e, we);
                total++;
                if (e !== we || done !== 1'b0 || map !== exp_map() || sel_card !== exp_sel()) begin
                    bad++; $display("FAIL random_write pos=%0d: err=%b done=%b required %b/0 map_ok=%b sel_ok=%b",
                                    p, e, done, we, map === exp_map(), sel_card === exp_sel());
                end
            end else if (r < 5) begin
                wait_ready(ok);
                if (ok) begin
                    wr_en = 1'b1; wr_pos = 8'(p); wr_type = 6'(t);
                    cmd_valid = 1'b1; cmd = 3'(c);
                    @(posedge clk); #1;
                    wr_en = 1'b0; cmd_valid = 1'b0;
                    model_write(p, t, we);
                    model_cmd(c, ee);
                    @(negedge clk);
                    total++;
                    if (err !== we || done !== 1'b0) begin
                        bad++; $display("FAIL combo_write_phase: err=%b done=%b required %b/0", err, done, we);
                    end
                    @(negedge clk);
                    $display("combo pos=%0d type=%0d op=%0d done=%b err=%b", p, t, c, done, err);
                    total++;
                    if (done !== 1'b1 || err !== ee || map !== exp_map() || sel_card !== exp_sel() ||
                        cursor_pos !== exp_pos() || held !== m_held || held_type !== 6'(m_type)) begin
                        bad++; $display("FAIL combo_cmd_phase op=%0d: done=%b err=%b cursor=%0d held=%b type=%0d required 1/%b/%0d/%b/%0d",
                                        c, done, err, cursor_pos, held, held_type, ee, exp_pos(), m_held, m_type);
                    end
                end
            end else begin
                run_cmd(c, d, e, ee);
                total++;
                if (d !== 1'b1 || e !== ee || map !== exp_map() || sel_card !== exp_sel() ||
                    cursor_pos !== exp_pos() || held !== m_held || held_type !== 6'(m_type)) begin
                    bad++; $display("FAIL random_cmd op=%0d: done=%b err=%b cursor=%0d held=%b type=%0d required 1/%b/%0d/%b/%0d",
                                    c, d, e, cursor_pos, held, held_type, ee, exp_pos(), m_held, m_type);
                end
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        logic e; bit ee, ok;
        do_write(int'(exp_pos()), 11, e, ee);
        wait_ready(ok);
        if (!ok) return;
        cmd_valid = 1'b1; cmd = 3'd6;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        $display("reset during exec held=%b done=%b cursor=%0d", held, done, cursor_pos);
        total++;
        if (done !== 1'b0 || held !== 1'b0 || held_type !== 6'd54 || map !== exp_map() ||
            sel_card !== '0 || cursor_pos !== 8'd0 || cmd_ready !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_mid_exec: done=%b held=%b type=%0d cursor=%0d ready=%b map_ok=%b required 0/0/54/0/0/1",
                            done, held, held_type, cursor_pos, cmd_ready, map === exp_map());
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL ready_after_reset: cmd_ready=%b done=%b required 1/0", cmd_ready, done);
        end
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_select();
        test_pick_place();
        test_write_drop();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
